// File: rtl/jk_cmd_pkg.sv
// jk_cmd_pkg: shared types and helpers for the JK command driver.
//   jk_cmd_t   - command latched from the button priority encoder
//   jk_state_t - command FSM state
//   cmd_to_jk  - maps a command onto the {j,k} pair driven downstream
package jk_cmd_pkg;

    typedef enum logic [1:0] {
        CMD_HOLD = 2'd0,
        CMD_SET  = 2'd1,
        CMD_CLR  = 2'd2,
        CMD_TOG  = 2'd3
    } jk_cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DRIVE   = 2'd1,
        ST_HOLDOFF = 2'd2
    } jk_state_t;

    // Returns {j,k}; hold (00) is the safe fallback for anything unexpected.
    function automatic logic [1:0] cmd_to_jk(input jk_cmd_t cmd);
        logic [1:0] jk;
        case (cmd)
            CMD_SET: jk = 2'b10;
            CMD_CLR: jk = 2'b01;
            CMD_TOG: jk = 2'b11;
            default: jk = 2'b00;
        endcase
        return jk;
    endfunction

endpackage

// File: rtl/jk_cmd_driver_btn_debounce.sv
// btn_debounce: synchroniser, debounce counter, debounced level and
// registered rising-edge pulse for one raw push button.
// Ports:
//   clk, rst - clock, asynchronous active-high reset
//   btn      - raw asynchronous button input
//   deb      - debounced level
//   rise     - one-cycle pulse, registered one edge after deb rises
module btn_debounce #(
    parameter int DEB_CYCLES  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic deb,
    output logic rise
);

    localparam int CW = $clog2(DEB_CYCLES + 1);

    logic [SYNC_STAGES-1:0] sync_r;
    logic [CW-1:0]          cnt_r;
    logic                   deb_r;
    logic                   deb_d_r;
    logic                   rise_r;
    logic                   sync_s;

    assign sync_s = sync_r[SYNC_STAGES-1];

    // Synchroniser chain; the last stage is the only one the logic looks at.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_r <= '0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], btn};
        end
    end

    // Debounce: level flips only after DEB_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= '0;
            deb_r <= 1'b0;
        end else if (sync_s == deb_r) begin
            cnt_r <= '0;
        end else if (cnt_r == CW'(DEB_CYCLES - 1)) begin
            cnt_r <= '0;
            deb_r <= ~deb_r;
        end else begin
            cnt_r <= cnt_r + CW'(1);
        end
    end

    // Rising-edge detector on the debounced level, output registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deb_d_r <= 1'b0;
            rise_r  <= 1'b0;
        end else begin
            deb_d_r <= deb_r;
            rise_r  <= deb_r & ~deb_d_r;
        end
    end

    assign deb  = deb_r;
    assign rise = rise_r;

endmodule

// File: rtl/jk_cmd_driver.sv
// jk_cmd_driver: turns three raw buttons (set, clear, toggle) into exactly
// one single-cycle JK command per press, then holds off until every button
// is released.
// Ports:
//   clk, rst                   - clock, asynchronous active-high reset
//   set_btn, clr_btn, tog_btn  - raw asynchronous buttons
//   j, k                       - registered JK inputs for the downstream flop
//   busy                       - high whenever the FSM is not idle
//   cmd_count[7:0]             - saturating count of issued commands
//                                (only when JK_CMD_COUNT_EN is defined)
module jk_cmd_driver
    import jk_cmd_pkg::*;
#(
    parameter int DEB_CYCLES  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       set_btn,
    input  logic       clr_btn,
    input  logic       tog_btn,
    output logic       j,
    output logic       k,
    output logic       busy
`ifdef JK_CMD_COUNT_EN
    ,
    output logic [7:0] cmd_count
`endif
);

    logic      deb_set_s, deb_clr_s, deb_tog_s;
    logic      rise_set_s, rise_clr_s, rise_tog_s;
    jk_cmd_t   cmd_s;
    jk_state_t state_r, state_nxt_s;
    logic [1:0] jk_nxt_s;
    logic      j_r, k_r, busy_r;
    logic      enter_drive_s;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES), .SYNC_STAGES(SYNC_STAGES)) u_set (
        .clk(clk), .rst(rst), .btn(set_btn), .deb(deb_set_s), .rise(rise_set_s));
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES), .SYNC_STAGES(SYNC_STAGES)) u_clr (
        .clk(clk), .rst(rst), .btn(clr_btn), .deb(deb_clr_s), .rise(rise_clr_s));
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES), .SYNC_STAGES(SYNC_STAGES)) u_tog (
        .clk(clk), .rst(rst), .btn(tog_btn), .deb(deb_tog_s), .rise(rise_tog_s));

    // Priority encoder: clear beats set beats toggle on simultaneous rises.
    always_comb begin
        cmd_s = CMD_HOLD;
        if (rise_clr_s) begin
            cmd_s = CMD_CLR;
        end else if (rise_set_s) begin
            cmd_s = CMD_SET;
        end else if (rise_tog_s) begin
            cmd_s = CMD_TOG;
        end else begin
            cmd_s = CMD_HOLD;
        end
    end

    assign enter_drive_s = (state_r == ST_IDLE) && (cmd_s != CMD_HOLD);

    // Next-state logic; rises seen outside IDLE are simply dropped.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (enter_drive_s) begin
                    state_nxt_s = ST_DRIVE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_DRIVE: state_nxt_s = ST_HOLDOFF;
            ST_HOLDOFF: begin
                if (!deb_set_s && !deb_clr_s && !deb_tog_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_HOLDOFF;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // The command is captured straight into the j/k registers on DRIVE entry,
    // so j/k are non-zero only during the single DRIVE cycle.
    always_comb begin
        if (enter_drive_s) begin
            jk_nxt_s = cmd_to_jk(cmd_s);
        end else begin
            jk_nxt_s = 2'b00;
        end
    end

    // State and registered outputs; busy tracks the registered state exactly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            j_r     <= 1'b0;
            k_r     <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            j_r     <= jk_nxt_s[1];
            k_r     <= jk_nxt_s[0];
            busy_r  <= (state_nxt_s != ST_IDLE);
        end
    end

    assign j    = j_r;
    assign k    = k_r;
    assign busy = busy_r;

`ifdef JK_CMD_COUNT_EN
    logic [7:0] cmd_count_r;

    // Saturating command counter, bumped on every DRIVE entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_count_r <= 8'd0;
        end else if (enter_drive_s && (cmd_count_r != 8'hFF)) begin
            cmd_count_r <= cmd_count_r + 8'd1;
        end else begin
            cmd_count_r <= cmd_count_r;
        end
    end

    assign cmd_count = cmd_count_r;
`endif

endmodule
